// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory port.
// Each granted access holds the memory for WAIT_CYC cycles, then acks its requester for one cycle.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iReq0,
  input  logic        iWr0,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iWrData0,
  output logic        oAck0,
  output logic [31:0] oRdData0,
  input  logic        iReq1,
  input  logic        iWr1,
  input  logic [31:0] iAddr1,
  input  logic [31:0] iWrData1,
  output logic        oAck1,
  output logic [31:0] oRdData1,
  output logic        oMemRd,
  output logic        oMemWr,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWrData,
  input  logic [31:0] iMemRdData,
  input  logic        iMemAccessable,
  output logic        oErr,
  output logic        oBusy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lat_wr;
  logic             lat_id;
  logic             last_id;
  logic [DW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic [DW-1:0]    rd_q;
  logic             err_q;
  logic             any_req_c;
  logic             gnt_id_c;
  logic             last_cyc_c;

  // Round-robin pick: a tie goes to whoever was not granted last.
  always_comb begin
    any_req_c = iReq0 | iReq1;
    if (iReq0 && iReq1) gnt_id_c = ~last_id;
    else                gnt_id_c = iReq1;
    last_cyc_c = (cnt == CNT_W'(1));
  end

  // State register plus the per-access latches it controls.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_id   <= 1'b1;
      lat_wr    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            lat_id    <= gnt_id_c;
            last_id   <= gnt_id_c;
            lat_wr    <= gnt_id_c ? iWr1 : iWr0;
            lat_addr  <= gnt_id_c ? iAddr1 : iAddr0;
            lat_wdata <= gnt_id_c ? iWrData1 : iWrData0;
            cnt       <= CNT_W'(WAIT_CYC);
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (last_cyc_c) begin
            rd_q  <= (!lat_wr && iMemAccessable) ? iMemRdData : '0;
            err_q <= ~iMemAccessable;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; memory strobes are live only inside ACCESS.
  always_comb begin
    state_nxt  = state;
    oMemRd     = 1'b0;
    oMemWr     = 1'b0;
    oMemAddr   = '0;
    oMemWrData = '0;
    oAck0      = 1'b0;
    oAck1      = 1'b0;
    oRdData0   = '0;
    oRdData1   = '0;
    oErr       = 1'b0;
    oBusy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req_c) state_nxt = ACCESS;
      end
      ACCESS: begin
        oMemAddr   = lat_addr;
        oMemWrData = lat_wdata;
        oMemRd     = ~lat_wr;
        // A reset landing on the final cycle must not leave a stray write behind.
        oMemWr     = lat_wr & last_cyc_c & iMemAccessable & iRst_n;
        if (last_cyc_c) state_nxt = ACK;
      end
      ACK: begin
        oAck0     = ~lat_id;
        oAck1     = lat_id;
        oRdData0  = lat_id ? '0 : rd_q;
        oRdData1  = lat_id ? rd_q : '0;
        oErr      = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (WAIT_CYC 1, 3, 4) share one stimulus set.
// Each scenario checks the instance whose wait setting it targets.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, wr0, req1, wr1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rd_val;

  logic        ack0 [3];
  logic        ack1 [3];
  logic        mem_rd [3];
  logic        mem_wr [3];
  logic        err [3];
  logic        busy [3];
  logic        acc [3];
  logic [31:0] rdd0 [3];
  logic [31:0] rdd1 [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    // Addresses with top nibble F decode as unaccessable.
    assign acc[g]       = (mem_addr[g][31:28] != 4'hF);
    assign mem_rdata[g] = rd_val;
    dmem_arbiter #(.WAIT_CYC(WC)) u_dut (
      .iClk(clk), .iRst_n(rst_n),
      .iReq0(req0), .iWr0(wr0), .iAddr0(addr0), .iWrData0(wdata0),
      .oAck0(ack0[g]), .oRdData0(rdd0[g]),
      .iReq1(req1), .iWr1(wr1), .iAddr1(addr1), .iWrData1(wdata1),
      .oAck1(ack1[g]), .oRdData1(rdd1[g]),
      .oMemRd(mem_rd[g]), .oMemWr(mem_wr[g]), .oMemAddr(mem_addr[g]),
      .oMemWrData(mem_wdata[g]), .iMemRdData(mem_rdata[g]),
      .iMemAccessable(acc[g]), .oErr(err[g]), .oBusy(busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_val = 32'h0;
    rst_n  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++;
      if ({busy[g], ack0[g], ack1[g], mem_rd[g], mem_wr[g], err[g]} !== 6'b0) begin
        bad++;
        $display("FAIL reset_flags inst=%0d got=%b%b%b%b%b%b exp=000000", g,
                 busy[g], ack0[g], ack1[g], mem_rd[g], mem_wr[g], err[g]);
      end
      total++;
      if ((mem_addr[g] | mem_wdata[g] | rdd0[g] | rdd1[g]) !== 32'h0) begin
        bad++;
        $display("FAIL reset_buses inst=%0d addr=%h wdata=%h rd0=%h rd1=%h exp=0", g,
                 mem_addr[g], mem_wdata[g], rdd0[g], rdd1[g]);
      end
    end
    tick();
    rst_n = 1'b1;
  endtask

  // WAIT_CYC=1 write from requester 0.
  task automatic test_write_w1();
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hA5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (mem_wr[0] !== (c == 1)) begin
        bad++; $display("FAIL w1_memwr c=%0d got=%b exp=%b", c, mem_wr[0], c == 1);
      end
      total++;
      if (ack0[0] !== (c == 2) || ack1[0] !== 1'b0) begin
        bad++; $display("FAIL w1_ack c=%0d got=%b/%b exp=%b/0", c, ack0[0], ack1[0], c == 2);
      end
      total++;
      if (rdd0[0] !== 32'h0 || mem_rd[0] !== 1'b0) begin
        bad++; $display("FAIL w1_rd c=%0d rd0=%h memrd=%b exp=0/0", c, rdd0[0], mem_rd[0]);
      end
      if (c == 1) begin
        total++;
        if (mem_addr[0] !== 32'h10 || mem_wdata[0] !== 32'hA5) begin
          bad++; $display("FAIL w1_bus got=%h/%h exp=00000010/000000a5", mem_addr[0], mem_wdata[0]);
        end
      end
      tick();
      if (c == 2) req0 = 1'b0;
    end
  endtask

  // WAIT_CYC=3 read from requester 1.
  task automatic test_read_w3();
    do_reset();
    rd_val = 32'h1234;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (mem_rd[1] !== (c >= 1 && c <= 3) || mem_wr[1] !== 1'b0) begin
        bad++; $display("FAIL r3_strobe c=%0d rd=%b wr=%b exp=%b/0", c, mem_rd[1], mem_wr[1], c >= 1 && c <= 3);
      end
      total++;
      if (mem_addr[1] !== ((c >= 1 && c <= 3) ? 32'h20 : 32'h0)) begin
        bad++; $display("FAIL r3_addr c=%0d got=%h", c, mem_addr[1]);
      end
      total++;
      if (ack1[1] !== (c == 4) || ack0[1] !== 1'b0) begin
        bad++; $display("FAIL r3_ack c=%0d got=%b/%b exp=0/%b", c, ack0[1], ack1[1], c == 4);
      end
      total++;
      if (rdd1[1] !== ((c == 4) ? 32'h1234 : 32'h0) || err[1] !== 1'b0) begin
        bad++; $display("FAIL r3_data c=%0d got=%h err=%b", c, rdd1[1], err[1]);
      end
      total++;
      if (busy[1] !== (c >= 1 && c <= 4)) begin
        bad++; $display("FAIL r3_busy c=%0d got=%b exp=%b", c, busy[1], c >= 1 && c <= 4);
      end
      tick();
      if (c == 4) req1 = 1'b0;
    end
  endtask

  // Both requesting after reset: grants 0, 1, then 0 again, one idle cycle between.
  task automatic test_round_robin();
    logic [31:0] ea;
    do_reset();
    rd_val = 32'h5555;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h100;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h200;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      case (c)
        1, 7:    ea = 32'h100;
        4:       ea = 32'h200;
        default: ea = 32'h0;
      endcase
      total++;
      if (mem_addr[0] !== ea) begin
        bad++; $display("FAIL rr_addr c=%0d got=%h exp=%h", c, mem_addr[0], ea);
      end
      total++;
      if (ack0[0] !== (c == 2 || c == 8) || ack1[0] !== (c == 5)) begin
        bad++; $display("FAIL rr_ack c=%0d got=%b/%b", c, ack0[0], ack1[0]);
      end
      total++;
      if (busy[0] !== !(c == 0 || c == 3 || c == 6)) begin
        bad++; $display("FAIL rr_busy c=%0d got=%b", c, busy[0]);
      end
      if (c == 2 || c == 5) begin
        total++;
        if (((c == 2) ? rdd0[0] : rdd1[0]) !== 32'h5555 || err[0] !== 1'b0) begin
          bad++; $display("FAIL rr_data c=%0d rd0=%h rd1=%h err=%b exp=00005555", c, rdd0[0], rdd1[0], err[0]);
        end
      end
      tick();
      if (c == 2) req0 = 1'b0;
      if (c == 5) req0 = 1'b1;
      if (c == 8) idle_inputs();
    end
  endtask

  // Unaccessable read and write on WAIT_CYC=1.
  task automatic test_unaccessable();
    do_reset();
    rd_val = 32'hDEADBEEF;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'hF000_0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (mem_rd[0] !== (c == 1)) begin
        bad++; $display("FAIL ua_rd_strobe c=%0d got=%b", c, mem_rd[0]);
      end
      total++;
      if (ack0[0] !== (c == 2) || err[0] !== (c == 2) || rdd0[0] !== 32'h0) begin
        bad++; $display("FAIL ua_rd c=%0d ack=%b err=%b rd=%h exp=%b/%b/0", c, ack0[0], err[0], rdd0[0], c == 2, c == 2);
      end
      tick();
      if (c == 2) req0 = 1'b0;
    end
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'hF000_0004; wdata1 = 32'h11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (mem_wr[0] !== 1'b0) begin
        bad++; $display("FAIL ua_wr_strobe c=%0d got=%b exp=0", c, mem_wr[0]);
      end
      total++;
      if (ack1[0] !== (c == 2) || err[0] !== (c == 2) || rdd1[0] !== 32'h0) begin
        bad++; $display("FAIL ua_wr c=%0d ack=%b err=%b rd=%h exp=%b/%b/0", c, ack1[0], err[0], rdd1[0], c == 2, c == 2);
      end
      tick();
      if (c == 2) req1 = 1'b0;
    end
  endtask

  // WAIT_CYC=4: reset in the second access cycle aborts the write; a fresh tie goes to requester 0.
  task automatic test_reset_abort();
    do_reset();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h77;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      total++;
      if (mem_wr[2] !== (c == 8)) begin
        bad++; $display("FAIL ab_memwr c=%0d got=%b exp=%b", c, mem_wr[2], c == 8);
      end
      total++;
      if (ack0[2] !== (c == 9) || ack1[2] !== 1'b0) begin
        bad++; $display("FAIL ab_ack c=%0d got=%b/%b exp=%b/0", c, ack0[2], ack1[2], c == 9);
      end
      total++;
      if (busy[2] !== (c == 1 || c == 2 || (c >= 5 && c <= 9))) begin
        bad++; $display("FAIL ab_busy c=%0d got=%b", c, busy[2]);
      end
      if (c >= 5 && c <= 8) begin
        total++;
        if (mem_addr[2] !== 32'h50 || mem_wdata[2] !== 32'h99) begin
          bad++; $display("FAIL ab_bus c=%0d got=%h/%h exp=00000050/00000099", c, mem_addr[2], mem_wdata[2]);
        end
      end
      tick();
      case (c)
        0: req0 = 1'b0;
        1: rst_n = 1'b0;
        2: rst_n = 1'b1;
        3: begin
          req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h99;
          req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h60; wdata1 = 32'h66;
        end
        4: req0 = 1'b0;
        9: idle_inputs();
        default: ;
      endcase
    end
  endtask

  initial begin
    idle_inputs();
    rst_n  = 1'b0;
    rd_val = '0;
    test_reset();
    test_write_w1();
    test_read_w3();
    test_round_robin();
    test_unaccessable();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WAIT_CYC, default 1, number of cycles a granted access drives the data memory before completion; legal range 1..15.
REQ-002 iClk  in  1  sole clock; all state updates on rising edge.
REQ-003 iRst_n  in  1  reset, synchronous, active-low.
REQ-004 iReq0  in  1  requester 0 (CPU core) access request, level.
REQ-005 iWr0  in  1  requester 0 access type: 1 write, 0 read.
REQ-006 iAddr0  in  32  requester 0 byte address.
REQ-007 iWrData0  in  32  requester 0 write data.
REQ-008 oAck0  out  1  requester 0 completion, one-cycle pulse.
REQ-009 oRdData0  out  32  requester 0 read data, valid only while oAck0=1, else 0.
REQ-010 iReq1, iWr1, iAddr1, iWrData1, oAck1, oRdData1  same widths/meanings as REQ-004..009 for requester 1 (loader/debug port).
REQ-011 oMemRd  out  1  data memory read strobe.
REQ-012 oMemWr  out  1  data memory write strobe.
REQ-013 oMemAddr  out  32  data memory address.
REQ-014 oMemWrData  out  32  data memory write data.
REQ-015 iMemRdData  in  32  data memory read data, combinational from oMemAddr.
REQ-016 iMemAccessable  in  1  data memory address-decode valid, combinational from oMemAddr.
REQ-017 oErr  out  1  pulses with oAckN when the completed access hit an unaccessable address.
REQ-018 oBusy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, ACK; no other states.
REQ-020 IDLE: no request -> stay; any iReqN=1 -> latch winner's iWrN/iAddrN/iWrDataN and winner id into registers, load wait counter with WAIT_CYC, go ACCESS.
REQ-021 Arbitration round-robin: both requesting -> grant the requester not granted last; after reset requester 0 wins first tie.
REQ-022 Single requester SHALL be granted regardless of round-robin pointer; pointer updates only on grant.
REQ-023 ACCESS: oMemAddr/oMemWrData driven from latched registers every cycle; oMemRd=1 every cycle of a read; counter decrements each cycle; at count 1 go ACK.
REQ-024 oMemWr SHALL be 1 only in the final ACCESS cycle of a write and only if iMemAccessable=1 (exactly one write strobe per access).
REQ-025 Final ACCESS cycle of a read: register iMemRdData if iMemAccessable=1, else register 0; register error flag = !iMemAccessable for both types.
REQ-026 ACK: exactly one cycle; pulse oAckN for the granted requester only; oRdDataN = registered data (0 for writes); oErr = registered flag; then go IDLE.
REQ-027 Outside ACCESS, oMemRd=oMemWr=0, oMemAddr=0, oMemWrData=0.
REQ-028 Latency: iReqN sampled high in IDLE cycle t -> ACCESS cycles t+1..t+WAIT_CYC -> oAckN in cycle t+WAIT_CYC+1; back-to-back grants separated by one IDLE cycle.
REQ-029 Requests in ACCESS/ACK are not sampled; requester inputs may change after grant without effect on the granted access.
REQ-030 Requester SHALL drop iReqN on the edge ending its oAckN cycle; iReqN still high in the following IDLE cycle is a new request.

Reset
REQ-031 iRst_n=0 at an edge -> state IDLE, round-robin pointer = requester 1 (so requester 0 wins next tie), counter 0, all outputs 0.
REQ-032 Reset mid-ACCESS/ACK aborts the access: no oAckN, no further oMemWr, regardless of remaining count.

Verification
REQ-033 WAIT_CYC=1, iReq0 write addr 0x10 data 0xA5 at t -> oMemWr=1 only at t+1 with addr 0x10/data 0xA5; oAck0 at t+2, oRdData0=0.
REQ-034 WAIT_CYC=3, iReq1 read addr 0x20, iMemRdData=0x1234 -> oMemRd=1 t+1..t+3, oAck1 at t+4, oRdData1=0x1234, oAck0 never.
REQ-035 After reset, iReq0 and iReq1 both held, each dropping after own ack -> grants 0,1 alternating; second grant's ACCESS starts one IDLE after first ack.
REQ-036 Read with iMemAccessable=0 -> oAck and oErr together, oRdData=0; write with iMemAccessable=0 -> oMemWr never asserts, oErr=1.
REQ-037 WAIT_CYC=4, iRst_n=0 during second ACCESS cycle of a write -> no oMemWr, no oAck, oBusy=0 next cycle; fresh request after release completes normally with requester 0 winning tie.
